// File: rtl/err_pwr_meter_pkg.sv
// Shared definitions for the windowed error-power meter: FSM states and the
// default window length.
package err_pwr_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int LFSR_LEN = 20;

endpackage

// File: rtl/err_sq_stage.sv
// S1 register stage: captures the error sample, its full-width square and the
// window tags {vld, first, last}. Advances only on clk_en.
module err_sq_stage #(
  parameter int DATA_W = 18
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_en,
  input  logic                       clr,
  input  logic                       vld_in,
  input  logic                       first_in,
  input  logic                       last_in,
  input  logic signed [DATA_W-1:0]   err,
  output logic                       vld_p1,
  output logic                       first_p1,
  output logic                       last_p1,
  output logic signed [DATA_W-1:0]   err_p1,
  output logic [2*DATA_W-1:0]        sq_p1
);

  logic signed [2*DATA_W-1:0] err_x;
  logic signed [2*DATA_W-1:0] sq;

  // The square of the most negative sample still fits in 2*DATA_W bits.
  assign err_x = (2*DATA_W)'(err);
  assign sq    = err_x * err_x;

  // ---- stage p1: tags ----
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else if (clk_en) begin
      vld_p1   <= vld_in;
      first_p1 <= first_in;
      last_p1  <= last_in;
    end
  end

  // ---- stage p1: data ----
  always_ff @(posedge clk) begin
    if (reset) begin
      err_p1 <= '0;
      sq_p1  <= '0;
    end else if (clk_en) begin
      err_p1 <= err;
      sq_p1  <= $unsigned(sq);
    end
  end

endmodule

// File: rtl/err_pwr_meter.sv
// Windowed error-power meter: accumulates err^2 and err over 2^LOG2_WIN
// enabled samples and dumps sum, mean square and signed error sum.
module err_pwr_meter
  import err_pwr_meter_pkg::*;
#(
  parameter int ERR_W      = 18,
  parameter int LOG2_WIN   = LFSR_LEN,
  parameter int CONTINUOUS = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clk_en,
  input  logic                              start,
  input  logic                              abort,
  input  logic signed [ERR_W-1:0]           err,
  output logic                              busy,
  output logic                              dump_valid,
  output logic [2*ERR_W+LOG2_WIN-1:0]       sum_sq,
  output logic [2*ERR_W-1:0]                mean_sq,
  output logic signed [ERR_W+LOG2_WIN-1:0]  sum_err
);

  localparam int SQ_W    = 2 * ERR_W;
  localparam int SUMSQ_W = SQ_W + LOG2_WIN;
  localparam int SUME_W  = ERR_W + LOG2_WIN;

  function automatic logic [SQ_W-1:0] mean_of(input logic [SUMSQ_W-1:0] s);
    return s[SUMSQ_W-1:LOG2_WIN];
  endfunction

  state_t                     state, state_nxt;
  logic [LOG2_WIN-1:0]        cnt;
  logic                       accept, first_p0, last_p0;
  logic                       vld_p1, first_p1, last_p1;
  logic signed [ERR_W-1:0]    err_p1;
  logic [SQ_W-1:0]            sq_p1;

  assign busy     = (state != ST_IDLE);
  assign accept   = clk_en && (state == ST_RUN) && !abort;
  assign first_p0 = (cnt == '0);
  assign last_p0  = &cnt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (CONTINUOUS == 0 && accept && last_p0) state_nxt = ST_FLUSH;
      ST_FLUSH: if (clk_en) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // ---- stage p0: sample counter ----
  always_ff @(posedge clk) begin
    if (reset || abort)                cnt <= '0;
    else if (state == ST_IDLE && start) cnt <= '0;
    else if (accept)                   cnt <= cnt + LOG2_WIN'(1);
  end

  err_sq_stage #(.DATA_W(ERR_W)) u_s1 (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .clr      (abort),
    .vld_in   (accept),
    .first_in (first_p0),
    .last_in  (last_p0),
    .err      (err),
    .vld_p1   (vld_p1),
    .first_p1 (first_p1),
    .last_p1  (last_p1),
    .err_p1   (err_p1),
    .sq_p1    (sq_p1)
  );

  // ---- stage p2: accumulators and dump ----
  logic                       absorb, dump;
  logic [SUMSQ_W-1:0]         acc_sq_p2, base_sq, tot_sq;
  logic signed [SUME_W-1:0]   acc_err_p2, base_err, err_ext, tot_err;

  assign absorb   = clk_en && vld_p1 && !abort;
  assign dump     = absorb && last_p1;
  assign base_sq  = first_p1 ? '0 : acc_sq_p2;
  assign base_err = first_p1 ? '0 : acc_err_p2;
  assign err_ext  = SUME_W'(err_p1);
  assign tot_sq   = base_sq + SUMSQ_W'(sq_p1);
  assign tot_err  = base_err + err_ext;

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      acc_sq_p2  <= '0;
      acc_err_p2 <= '0;
    end else if (absorb) begin
      acc_sq_p2  <= tot_sq;
      acc_err_p2 <= tot_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dump_valid <= 1'b0;
      sum_sq     <= '0;
      mean_sq    <= '0;
      sum_err    <= '0;
    end else begin
      dump_valid <= dump;
      if (dump) begin
        sum_sq  <= tot_sq;
        mean_sq <= mean_of(tot_sq);
        sum_err <= tot_err;
      end
    end
  end

endmodule

// File: tb/tb_err_pwr_meter.sv
// Bench for err_pwr_meter: single-shot and continuous instances, random
// windows, scoreboard queues drained by per-instance monitors.
module tb_err_pwr_meter;

  localparam int EW  = 18;
  localparam int LW  = 2;
  localparam int SQW = 2 * EW;
  localparam int SSW = SQW + LW;
  localparam int SEW = EW + LW;

  typedef struct {
    logic [SSW-1:0]        sq;
    logic [SQW-1:0]        m;
    logic signed [SEW-1:0] e;
    int                    cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic                  s_clk_en = 1'b0, s_start = 1'b0, s_abort = 1'b0;
  logic signed [EW-1:0]  s_err = '0;
  logic                  s_busy, s_dv;
  logic [SSW-1:0]        s_sum_sq;
  logic [SQW-1:0]        s_mean;
  logic signed [SEW-1:0] s_sum_err;

  logic                  c_clk_en = 1'b0, c_start = 1'b0, c_abort = 1'b0;
  logic signed [EW-1:0]  c_err = '0;
  logic                  c_busy, c_dv;
  logic [SSW-1:0]        c_sum_sq;
  logic [SQW-1:0]        c_mean;
  logic signed [SEW-1:0] c_sum_err;

  err_pwr_meter #(.ERR_W(EW), .LOG2_WIN(LW), .CONTINUOUS(0)) dut (
    .clk(clk), .reset(reset), .clk_en(s_clk_en), .start(s_start), .abort(s_abort),
    .err(s_err), .busy(s_busy), .dump_valid(s_dv), .sum_sq(s_sum_sq),
    .mean_sq(s_mean), .sum_err(s_sum_err)
  );

  err_pwr_meter #(.ERR_W(EW), .LOG2_WIN(LW), .CONTINUOUS(1)) dut_c (
    .clk(clk), .reset(reset), .clk_en(c_clk_en), .start(c_start), .abort(c_abort),
    .err(c_err), .busy(c_busy), .dump_valid(c_dv), .sum_sq(c_sum_sq),
    .mean_sq(c_mean), .sum_err(c_sum_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t s_q[$];
  exp_t c_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Reference: plain sums over the window, mean = floor(sum_sq / window length).
  function automatic exp_t model(input logic signed [EW-1:0] w[4], input int c);
    exp_t r;
    longint ssq = 0;
    longint se = 0;
    for (int i = 0; i < 4; i++) begin
      ssq += longint'(w[i]) * longint'(w[i]);
      se  += longint'(w[i]);
    end
    r.sq  = SSW'(ssq);
    r.m   = SQW'(ssq / 4);
    r.e   = SEW'(se);
    r.cyc = c;
    return r;
  endfunction

  logic                  s_rst_prev = 1'b0;
  logic [SSW-1:0]        s_h_sq = '0;
  logic [SQW-1:0]        s_h_m = '0;
  logic signed [SEW-1:0] s_h_e = '0;

  always @(negedge clk) begin : s_mon
    exp_t x;
    if (s_rst_prev) begin
      chk("s_reset_busy", s_busy, 0);
      chk("s_reset_dv", s_dv, 0);
      s_h_sq = '0; s_h_m = '0; s_h_e = '0;
    end
    if (s_dv) begin
      if (s_q.size() == 0) chk("s_unexpected_dump", 1, 0);
      else begin
        x = s_q.pop_front();
        chk("s_sum_sq", s_sum_sq, x.sq);
        chk("s_mean_sq", s_mean, x.m);
        chk("s_sum_err", s_sum_err, x.e);
        chk("s_dump_cycle", cyc, x.cyc);
        s_h_sq = x.sq; s_h_m = x.m; s_h_e = x.e;
      end
    end else begin
      chk("s_hold_sum_sq", s_sum_sq, s_h_sq);
      chk("s_hold_mean_sq", s_mean, s_h_m);
      chk("s_hold_sum_err", s_sum_err, s_h_e);
    end
    s_rst_prev = reset;
  end

  logic                  c_rst_prev = 1'b0;
  logic [SSW-1:0]        c_h_sq = '0;
  logic [SQW-1:0]        c_h_m = '0;
  logic signed [SEW-1:0] c_h_e = '0;

  always @(negedge clk) begin : c_mon
    exp_t x;
    if (c_rst_prev) begin
      chk("c_reset_busy", c_busy, 0);
      chk("c_reset_dv", c_dv, 0);
      c_h_sq = '0; c_h_m = '0; c_h_e = '0;
    end
    if (c_dv) begin
      if (c_q.size() == 0) chk("c_unexpected_dump", 1, 0);
      else begin
        x = c_q.pop_front();
        chk("c_sum_sq", c_sum_sq, x.sq);
        chk("c_mean_sq", c_mean, x.m);
        chk("c_sum_err", c_sum_err, x.e);
        chk("c_dump_cycle", cyc, x.cyc);
        c_h_sq = x.sq; c_h_m = x.m; c_h_e = x.e;
      end
    end else begin
      chk("c_hold_sum_sq", c_sum_sq, c_h_sq);
      chk("c_hold_mean_sq", c_mean, c_h_m);
      chk("c_hold_sum_err", c_sum_err, c_h_e);
    end
    c_rst_prev = reset;
  end

  task automatic s_tick(input bit en);
    s_clk_en = en;
    if (!en) s_err = EW'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic c_tick(input bit en);
    c_clk_en = en;
    if (!en) c_err = EW'($urandom);
    @(posedge clk);
    #1;
  endtask

  // One single-shot window; abort_after < 4 aborts once that many samples are in.
  task automatic s_window(input logic signed [EW-1:0] w[4], input int div, input int abort_after);
    s_start = 1'b1; s_tick(0); s_start = 1'b0;
    chk("s_busy_run", s_busy, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == abort_after) begin
        s_abort = 1'b1; s_tick(0); s_abort = 1'b0;
        chk("s_busy_abort", s_busy, 0);
        s_tick(1);
        return;
      end
      repeat (div - 1) s_tick(0);
      s_err = w[i];
      s_tick(1);
    end
    repeat (div - 1) s_tick(0);
    s_q.push_back(model(w, cyc + 1));
    s_err = EW'($urandom);
    s_tick(1);
    chk("s_busy_done", s_busy, 0);
    s_tick(1);
    s_tick(0);
  endtask

  task automatic c_stream(input int n, input bit rnd);
    logic signed [EW-1:0] w[4];
    exp_t px;
    bit pend;
    pend = 1'b0;
    c_start = 1'b1; c_tick(0); c_start = 1'b0;
    chk("c_busy_run", c_busy, 1);
    for (int i = 0; i < n; i++) begin
      if (rnd) for (int k = 0; k < 3 && $urandom_range(0, 2) == 0; k++) c_tick(0);
      if (pend) begin px.cyc = cyc + 1; c_q.push_back(px); pend = 1'b0; end
      c_err = rnd ? EW'($urandom) : ((i < 4) ? EW'(1) : EW'(2));
      w[i % 4] = c_err;
      c_tick(1);
      if (i % 4 == 3) begin px = model(w, 0); pend = 1'b1; end
    end
    if (pend) begin px.cyc = cyc + 1; c_q.push_back(px); end
    c_err = EW'(5);
    c_tick(1);
    chk("c_busy_stream", c_busy, 1);
    c_abort = 1'b1; c_tick(0); c_abort = 1'b0;
    chk("c_busy_abort", c_busy, 0);
    repeat (3) c_tick(1);
  endtask

  initial begin
    logic signed [EW-1:0] w[4];
    int t2[4];
    t2 = '{3, -3, 5, -1};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", s_busy, 0);
    chk("reset_sum_sq", s_sum_sq, 0);

    for (int i = 0; i < 4; i++) w[i] = EW'(t2[i]);
    s_window(w, 1, 4);
    for (int i = 0; i < 4; i++) w[i] = EW'(-131072);
    s_window(w, 1, 4);
    for (int i = 0; i < 4; i++) w[i] = EW'(t2[i]);
    s_window(w, 3, 4);

    for (int i = 0; i < 4; i++) w[i] = EW'($urandom);
    s_window(w, 1, 2);
    for (int i = 0; i < 4; i++) w[i] = EW'(2);
    s_window(w, 2, 4);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++)
        w[i] = ($urandom_range(0, 3) == 0) ? EW'(-131072) : EW'($urandom);
      s_window(w, $urandom_range(1, 3), 4);
    end

    s_start = 1'b1; s_tick(0); s_start = 1'b0;
    s_err = EW'(7); s_tick(1);
    s_err = EW'(-9); s_tick(1);
    reset = 1'b1; s_tick(1); reset = 1'b0;
    chk("reset_midrun_busy", s_busy, 0);
    repeat (3) s_tick(1);

    for (int i = 0; i < 4; i++) w[i] = EW'($urandom);
    s_window(w, 1, 4);

    c_stream(8, 1'b0);
    c_stream(16, 1'b1);

    repeat (4) s_tick(0);
    chk("s_queue_drained", s_q.size(), 0);
    chk("c_queue_drained", c_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
